// File: rtl/us_timer_bank.sv
// Microsecond timebase (exact 1 MHz tick, free-running counter with tear-free
// lo/hi read) plus a bank of one-shot/periodic down-counting timer channels.

module us_timer_chan #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load_wr,
    input  logic              ctrl_wr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] load,
    output logic [DATA_W-1:0] count,
    output logic              expire
);
    logic en, periodic;

    // A control write in a tick cycle wins, so that tick never expires the channel.
    assign expire = en && tick && !ctrl_wr && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            load     <= '0;
            count    <= '0;
            en       <= 1'b0;
            periodic <= 1'b0;
        end else begin
            if (load_wr)
                load <= din;
            if (ctrl_wr) begin
                en       <= din[0];
                periodic <= din[1];
                if (din[0])
                    count <= load;
            end else if (en && tick) begin
                if (count != '0)
                    count <= count - DATA_W'(1);
                else if (periodic)
                    count <= load;
                else
                    en <= 1'b0;
            end
        end
    end
endmodule

module us_timer_bank #(
    parameter int CLK_MHZ  = 25,
    parameter int CNT_W    = 32,
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_din,
    output logic [DATA_W-1:0] io_dout,
    output logic              us_tick,
    output logic [CNT_W-1:0]  us_cnt,
    output logic              irq
);
    localparam int PS_W   = $clog2(CLK_MHZ);
    localparam int SNAP_W = CNT_W - DATA_W;

    logic [PS_W-1:0]                      prescaler;
    logic [SNAP_W-1:0]                    snapshot;
    logic [CHANNELS-1:0]                  status, irq_en, expire, clr;
    logic [CHANNELS-1:0]                  load_wr, ctrl_wr;
    logic [CHANNELS-1:0][DATA_W-1:0]      ch_load, ch_count;
    logic [DATA_W-1:0]                    rd_data;

    // us_cnt steps on the same edge that raises us_tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            us_tick   <= 1'b0;
            us_cnt    <= '0;
        end else if (prescaler == PS_W'(CLK_MHZ - 1)) begin
            prescaler <= '0;
            us_tick   <= 1'b1;
            us_cnt    <= us_cnt + CNT_W'(1);
        end else begin
            prescaler <= prescaler + PS_W'(1);
            us_tick   <= 1'b0;
        end
    end

    always_comb begin
        load_wr = '0;
        ctrl_wr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            load_wr[c] = io_wr && (io_addr == ADDR_W'(4 + 2 * c));
            ctrl_wr[c] = io_wr && (io_addr == ADDR_W'(5 + 2 * c));
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        us_timer_chan #(.DATA_W(DATA_W)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .tick    (us_tick),
            .load_wr (load_wr[c]),
            .ctrl_wr (ctrl_wr[c]),
            .din     (io_din),
            .load    (ch_load[c]),
            .count   (ch_count[c]),
            .expire  (expire[c])
        );
    end

    assign clr = (io_wr && io_addr == ADDR_W'(2)) ? io_din[CHANNELS-1:0] : '0;

    // Set beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= '0;
            irq_en <= '0;
        end else begin
            status <= (status & ~clr) | expire;
            if (io_wr && io_addr == ADDR_W'(3))
                irq_en <= io_din[CHANNELS-1:0];
        end
    end

    assign irq = |(status & irq_en);

    always_comb begin
        rd_data = '0;
        case (io_addr)
            ADDR_W'(0): rd_data = us_cnt[DATA_W-1:0];
            ADDR_W'(1): rd_data[SNAP_W-1:0] = snapshot;
            ADDR_W'(2): rd_data[CHANNELS-1:0] = status;
            ADDR_W'(3): rd_data[CHANNELS-1:0] = irq_en;
            default: ;
        endcase
        for (int c = 0; c < CHANNELS; c++) begin
            if (io_addr == ADDR_W'(4 + 2 * c)) rd_data = ch_load[c];
            if (io_addr == ADDR_W'(5 + 2 * c)) rd_data = ch_count[c];
        end
    end

    // Reading the low half freezes the high half so a later US_HI read matches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_dout  <= '0;
            snapshot <= '0;
        end else if (io_rd) begin
            io_dout <= rd_data;
            if (io_addr == ADDR_W'(0))
                snapshot <= us_cnt[CNT_W-1:DATA_W];
        end
    end
endmodule
